// File: rtl/axi_stride_rd_master_if.sv
// AR/R read-channel bundle between the stride traffic master (master side)
// and the prefetcher slave port it drives.
interface axi_stride_rd_master_if #(
    parameter int ADDR_BITS       = 64,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 64
);
    logic                       m_ar_valid;
    logic                       m_ar_ready;
    logic [ADDR_BITS-1:0]       m_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len;
    logic [TID_WIDTH-1:0]       m_ar_id;
    logic                       m_r_valid;
    logic                       m_r_ready;
    logic [DATA_WIDTH-1:0]      m_r_data;
    logic                       m_r_last;
    logic [TID_WIDTH-1:0]       m_r_id;

    modport master (
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
    );

    modport slave (
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
    );
endinterface

// File: rtl/axi_stride_rd_master.sv
// Strided AXI read traffic master: issues cfg_num_reqs bursts at base+i*stride,
// retires them on R last, flags protocol errors. STRIDE_RD_MASTER_CHECKSUM_EN adds rd_checksum.
module axi_stride_rd_master #(
    parameter int ADDR_BITS            = 64,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 3,
    parameter int LOG_MAX_OUTSTANDING  = 2,
    parameter int REQ_CNT_WIDTH        = 16,
    localparam int DATA_WIDTH          = 8 << LOG_BLOCK_DATA_BYTES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_BITS-1:0]       cfg_base,
    input  logic [ADDR_BITS-1:0]       cfg_stride,
    input  logic [REQ_CNT_WIDTH-1:0]   cfg_num_reqs,
    input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
    input  logic [TID_WIDTH-1:0]       cfg_id,
    axi_stride_rd_master_if.master     bus,
`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]      rd_checksum,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                beat_cnt,
    output logic [2:0]                 error_code
);
    localparam int OW = LOG_MAX_OUTSTANDING + 1;
    localparam logic [OW-1:0] MAX_OUT = OW'(1) << LOG_MAX_OUTSTANDING;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [ADDR_BITS-1:0]       addr_q, addr_d, stride_q, stride_d;
    logic [REQ_CNT_WIDTH-1:0]   idx_q, idx_d, num_q, num_d;
    logic [BURST_LEN_WIDTH-1:0] len_q, len_d, bcnt_q, bcnt_d;
    logic [TID_WIDTH-1:0]       id_q, id_d;
    logic [OW-1:0]              outst_q, outst_d;
    logic [31:0]                beat_cnt_q, beat_cnt_d;
    logic [2:0]                 err_q, err_d;
    logic                       rdy_q, rdy_d;
    logic                       ar_valid, ar_hs, r_hs, stray, retire, active;

    assign active   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign ar_valid = (state_q == S_ISSUE) && (outst_q < MAX_OUT);
    assign ar_hs    = ar_valid && bus.m_ar_ready;
    assign r_hs     = bus.m_r_valid && rdy_q;
    // Beats with nothing in flight are errors and must not touch the counter.
    assign stray    = r_hs && (!active || outst_q == '0);
    assign retire   = r_hs && bus.m_r_last && !stray;

`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
`else
    logic unused_data;
    assign unused_data = ^bus.m_r_data;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        idx_d      = idx_q;
        num_d      = num_q;
        len_d      = len_q;
        bcnt_d     = bcnt_q;
        id_d       = id_q;
        outst_d    = outst_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        rdy_d      = 1'b1;
`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            addr_d     = cfg_base;
            stride_d   = cfg_stride;
            num_d      = cfg_num_reqs;
            len_d      = cfg_len;
            id_d       = cfg_id;
            idx_d      = '0;
            bcnt_d     = '0;
            beat_cnt_d = '0;
            err_d      = '0;
`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
            csum_d     = '0;
`endif
            state_d    = (cfg_num_reqs == '0) ? S_DONE : S_ISSUE;
        end
        if (ar_hs) begin
            addr_d = addr_q + stride_q;
            idx_d  = idx_q + REQ_CNT_WIDTH'(1);
            if (idx_q == num_q - REQ_CNT_WIDTH'(1)) state_d = S_DRAIN;
        end
        if (r_hs) begin
            if (beat_cnt_d != '1) beat_cnt_d = beat_cnt_d + 32'd1;
            if (bus.m_r_id != id_q) err_d[0] = 1'b1;
            if (bus.m_r_last != (bcnt_q == len_q)) err_d[1] = 1'b1;
            if (stray) err_d[2] = 1'b1;
            bcnt_d = bus.m_r_last ? '0 : bcnt_q + BURST_LEN_WIDTH'(1);
`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
            csum_d = csum_d ^ bus.m_r_data;
`endif
        end
        case ({ar_hs, retire})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase
        if (state_q == S_DRAIN && outst_d == '0) state_d = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            stride_q   <= '0;
            idx_q      <= '0;
            num_q      <= '0;
            len_q      <= '0;
            bcnt_q     <= '0;
            id_q       <= '0;
            outst_q    <= '0;
            beat_cnt_q <= '0;
            err_q      <= '0;
            rdy_q      <= 1'b0;
`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            len_q      <= len_d;
            bcnt_q     <= bcnt_d;
            id_q       <= id_d;
            outst_q    <= outst_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            rdy_q      <= rdy_d;
`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.m_ar_valid = ar_valid;
    assign bus.m_ar_addr  = addr_q;
    assign bus.m_ar_len   = len_q;
    assign bus.m_ar_id    = id_q;
    assign bus.m_r_ready  = rdy_q;
    assign busy           = active;
    assign done           = (state_q == S_DONE);
    assign beat_cnt       = beat_cnt_q;
    assign error_code     = err_q;
`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
    assign rd_checksum    = csum_q;
`endif
endmodule

// File: tb/tb_axi_stride_rd_master.sv
// Directed bench for axi_stride_rd_master, built with two outstanding bursts max.
module tb_axi_stride_rd_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] cfg_base, cfg_stride;
    logic [15:0] cfg_num_reqs;
    logic [7:0]  cfg_len, cfg_id;
    logic        busy, done;
    logic [31:0] beat_cnt;
    logic [2:0]  error_code;
`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
    logic [63:0] rd_checksum;
`endif
    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int hs_base;

    axi_stride_rd_master_if #(.ADDR_BITS(64), .BURST_LEN_WIDTH(8), .TID_WIDTH(8), .DATA_WIDTH(64)) bus ();

    axi_stride_rd_master #(.LOG_MAX_OUTSTANDING(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_num_reqs(cfg_num_reqs),
        .cfg_len(cfg_len), .cfg_id(cfg_id), .bus(bus),
`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
        .rd_checksum(rd_checksum),
`endif
        .busy(busy), .done(done), .beat_cnt(beat_cnt), .error_code(error_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.m_ar_valid && bus.m_ar_ready) hs_cnt <= hs_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [63:0] b, input logic [63:0] s, input logic [15:0] n,
                          input logic [7:0] l, input logic [7:0] id);
        cfg_base = b; cfg_stride = s; cfg_num_reqs = n; cfg_len = l; cfg_id = id;
        start = 1'b1;
        hs_base = hs_cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic rbeat(input logic v, input logic last, input logic [7:0] id, input logic [63:0] d);
        bus.m_r_valid = v; bus.m_r_last = last; bus.m_r_id = id; bus.m_r_data = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        cfg_base = '0; cfg_stride = '0; cfg_num_reqs = '0; cfg_len = '0; cfg_id = '0;
        bus.m_ar_ready = 1'b1;
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        tick(); tick();
        chk("rst_arvalid", bus.m_ar_valid, 0);
        chk("rst_addr", bus.m_ar_addr, 0);
        chk("rst_rready", bus.m_r_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_beats", beat_cnt, 0);
        chk("rst_err", error_code, 0);
        rst = 1'b0;
        tick();
        chk("rready_up", bus.m_r_ready, 1);

        // basic run, responses overlapping requests
        launch(64'h10, 64'd4, 16'd3, 8'd0, 8'd5);
        chk("t1_valid0", bus.m_ar_valid, 1);
        chk("t1_addr0", bus.m_ar_addr, 64'h10);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_addr1", bus.m_ar_addr, 64'h14);
        rbeat(1'b1, 1'b1, 8'd5, 64'd0);
        tick();
        chk("t1_addr2", bus.m_ar_addr, 64'h18);
        chk("t1_valid2", bus.m_ar_valid, 1);
        tick();
        chk("t1_drain_valid", bus.m_ar_valid, 0);
        chk("t1_drain_busy", busy, 1);
        tick();
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_beats", beat_cnt, 3);
        chk("t1_err", error_code, 0);
        chk("t1_hs", hs_cnt - hs_base, 3);

        // outstanding limit of 2, then AR backpressure
        launch(64'h100, 64'h40, 16'd4, 8'd0, 8'd5);
        chk("t2_addr0", bus.m_ar_addr, 64'h100);
        tick();
        chk("t2_addr1", bus.m_ar_addr, 64'h140);
        tick();
        chk("t2_full_valid", bus.m_ar_valid, 0);
        tick();
        chk("t2_full_valid2", bus.m_ar_valid, 0);
        chk("t2_hs2", hs_cnt - hs_base, 2);
        rbeat(1'b1, 1'b1, 8'd5, 64'd0);
        tick();
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        chk("t2_reopen_valid", bus.m_ar_valid, 1);
        chk("t2_reopen_addr", bus.m_ar_addr, 64'h180);
        bus.m_ar_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", bus.m_ar_valid, 1);
            chk("t3_hold_addr", bus.m_ar_addr, 64'h180);
        end
        chk("t3_no_dup", hs_cnt - hs_base, 2);
        bus.m_ar_ready = 1'b1;
        tick();
        chk("t2_addr3", bus.m_ar_addr, 64'h1C0);
        chk("t2_full3", bus.m_ar_valid, 0);
        rbeat(1'b1, 1'b1, 8'd5, 64'd0);
        tick();
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        chk("t2_valid3", bus.m_ar_valid, 1);
        tick();
        chk("t2_hs4", hs_cnt - hs_base, 4);
        chk("t2_drain", bus.m_ar_valid, 0);
        rbeat(1'b1, 1'b1, 8'd5, 64'd0);
        tick(); tick();
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        chk("t2_done", done, 1);
        chk("t2_beats", beat_cnt, 4);
        chk("t2_err", error_code, 0);

        // burst length checking
        launch(64'h0, 64'h20, 16'd2, 8'd3, 8'd5);
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            rbeat(1'b1, i == 3, 8'd5, 64'd0);
            tick();
        end
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        chk("t4_good_err", error_code, 0);
        chk("t4_still_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            rbeat(1'b1, i == 2, 8'd5, 64'd0);
            tick();
        end
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        chk("t4_short_err", error_code, 3'b010);
        chk("t4_done", done, 1);
        chk("t4_beats", beat_cnt, 7);

        // wrong id, then stray beat in DONE
        launch(64'h0, 64'h0, 16'd1, 8'd0, 8'd5);
        tick();
        rbeat(1'b1, 1'b1, 8'd6, 64'd0);
        tick();
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        chk("t4_id_err", error_code, 3'b001);
        rbeat(1'b1, 1'b1, 8'd5, 64'd0);
        tick();
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        chk("t4_stray_err", error_code, 3'b101);
        chk("t4_stray_beats", beat_cnt, 2);
        launch(64'h0, 64'd4, 16'd3, 8'd0, 8'd5);
        chk("t4_no_underflow", bus.m_ar_valid, 1);
        chk("t4_err_cleared", error_code, 0);
        tick(); tick(); tick();
        chk("t4_limit_hs", hs_cnt - hs_base, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // negative stride wraps silently
        launch(64'h4, 64'hFFFF_FFFF_FFFF_FFFC, 16'd3, 8'd0, 8'd5);
        chk("t5_addr0", bus.m_ar_addr, 64'h4);
        tick();
        chk("t5_addr1", bus.m_ar_addr, 64'h0);
        rbeat(1'b1, 1'b1, 8'd5, 64'd0);
        tick();
        chk("t5_addr2", bus.m_ar_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); tick();
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        chk("t5_done", done, 1);
        chk("t5_err", error_code, 0);

        // zero requests
        launch(64'h40, 64'd4, 16'd0, 8'd0, 8'd5);
        chk("t5_zero_done", done, 1);
        chk("t5_zero_valid", bus.m_ar_valid, 0);
        tick();
        chk("t5_zero_hs", hs_cnt - hs_base, 0);

        // reset while draining two bursts
        launch(64'h200, 64'd8, 16'd2, 8'd0, 8'd5);
        tick(); tick();
        chk("t6_drain_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("t6_valid", bus.m_ar_valid, 0);
        chk("t6_addr", bus.m_ar_addr, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_rready", bus.m_r_ready, 0);
        rst = 1'b0;
        tick();
        launch(64'h300, 64'd8, 16'd3, 8'd0, 8'd5);
        tick();
        rbeat(1'b1, 1'b1, 8'd5, 64'h01);
        tick();
        rbeat(1'b1, 1'b1, 8'd5, 64'h02);
        tick();
        rbeat(1'b1, 1'b1, 8'd5, 64'h04);
        tick();
        rbeat(1'b0, 1'b0, 8'd0, 64'd0);
        chk("t6_rerun_done", done, 1);
        chk("t6_rerun_err", error_code, 0);
        chk("t6_rerun_beats", beat_cnt, 3);
`ifdef STRIDE_RD_MASTER_CHECKSUM_EN
        chk("t6_checksum", rd_checksum, 64'h07);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
